signal_phase_scheduler: RTL

//  Round-robin green-time scheduler for an N-approach intersection. Latches vehicle

---
 rtl/signal_phase_scheduler_if.sv | 26 ++
 rtl/signal_phase_scheduler.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/signal_phase_scheduler_if.sv
// Lamp/request bundle for the intersection phase scheduler.
// The master side drives the sensors and timebase; the slave side is the scheduler.
interface signal_phase_scheduler_if #(
  parameter int unsigned NUM_APPR = 4
);
  localparam int unsigned AW = (NUM_APPR > 1) ? $clog2(NUM_APPR) : 1;

  logic                tick;
  logic [NUM_APPR-1:0] req;
  logic [NUM_APPR-1:0] green;
  logic [NUM_APPR-1:0] yellow;
  logic [NUM_APPR-1:0] red;
  logic [AW-1:0]       cur_appr;
  logic [NUM_APPR-1:0] pending;
  logic                grant;

  modport master (
    output tick, req,
    input  green, yellow, red, cur_appr, pending, grant
  );

  modport slave (
    input  tick, req,
    output green, yellow, red, cur_appr, pending, grant
  );
endinterface

// File: rtl/signal_phase_scheduler.sv
// Round-robin green-time scheduler for an N-approach intersection.
// Sequences GREEN -> YELLOW -> ALL_RED, one approach at a time, with
// min/max green and rest-in-green; all lamp outputs come from registers.
module signal_phase_scheduler #(
  parameter int unsigned NUM_APPR  = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MIN_GREEN = 10,
  parameter int unsigned MAX_GREEN = 30,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALL_RED_T = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  signal_phase_scheduler_if.slave  bus
);

  localparam int unsigned AW = (NUM_APPR > 1) ? $clog2(NUM_APPR) : 1;
  localparam int unsigned TW = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    timer;
  logic [AW-1:0]       cur;
  logic [NUM_APPR-1:0] pend;
  logic [NUM_APPR-1:0] green_r;
  logic [NUM_APPR-1:0] yellow_r;
  logic [NUM_APPR-1:0] red_r;
  logic                grant_r;

  logic [TW-1:0]       t_ext;
  logic [CNT_W-1:0]    timer_inc;
  logic [NUM_APPR-1:0] cur_mask;
  logic [NUM_APPR-1:0] others;
  logic [AW-1:0]       cand;
  logic [AW-1:0]       win_idx;
  logic                win_found;
  logic [NUM_APPR-1:0] win_mask;
  logic [NUM_APPR-1:0] set_mask;
  logic [NUM_APPR-1:0] clr_mask;
  logic [NUM_APPR-1:0] pend_nxt;
  logic                leave_all_red;
  logic                leave_green;
  logic                leave_yellow;

  // Ticks-in-state including the current tick, plus a saturating increment.
  assign t_ext     = {1'b0, timer} + TW'(1);
  assign timer_inc = (timer == {CNT_W{1'b1}}) ? timer : timer + CNT_W'(1);

  assign cur_mask  = NUM_APPR'(1) << cur;
  assign others    = pend & ~cur_mask;
  assign win_mask  = NUM_APPR'(1) << win_idx;

  // Round-robin search: start just after the current owner, owner itself last.
  always_comb begin
    win_idx   = cur;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_APPR; k++) begin
      cand = AW'((32'(cur) + k) % NUM_APPR);
      if (!win_found && pend[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Phase exit conditions; only a tick cycle can move the phase on.
  always_comb begin
    leave_all_red = 1'b0;
    leave_green   = 1'b0;
    leave_yellow  = 1'b0;
    if (bus.tick) begin
      case (state)
        ST_ALL_RED: leave_all_red = (t_ext >= TW'(ALL_RED_T)) && win_found;
        ST_GREEN:   leave_green   = (t_ext >= TW'(MIN_GREEN)) && (others != '0) &&
                                    (!bus.req[cur] || (t_ext >= TW'(MAX_GREEN)));
        ST_YELLOW:  leave_yellow  = (t_ext >= TW'(YELLOW_T));
        default:    leave_all_red = 1'b0;
      endcase
    end
  end

  // Request latch: the green approach does not latch its own sensor, and a
  // clear on green entry overrides a same-edge set.
  always_comb begin
    set_mask = bus.req;
    if (state == ST_GREEN) begin
      set_mask = bus.req & ~cur_mask;
    end
    clr_mask = leave_all_red ? win_mask : '0;
    pend_nxt = (pend | set_mask) & ~clr_mask;
  end

  // Phase FSM with timer, owner, request latch and registered lamp outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_ALL_RED;
      timer    <= '0;
      cur      <= '0;
      pend     <= '0;
      green_r  <= '0;
      yellow_r <= '0;
      red_r    <= '1;
      grant_r  <= 1'b0;
    end else begin
      pend    <= pend_nxt;
      grant_r <= 1'b0;
      case (state)
        ST_ALL_RED: begin
          if (leave_all_red) begin
            state   <= ST_GREEN;
            timer   <= '0;
            cur     <= win_idx;
            green_r <= win_mask;
            red_r   <= ~win_mask;
            grant_r <= 1'b1;
          end else if (bus.tick) begin
            timer <= timer_inc;
          end
        end
        ST_GREEN: begin
          if (leave_green) begin
            state    <= ST_YELLOW;
            timer    <= '0;
            green_r  <= '0;
            yellow_r <= cur_mask;
          end else if (bus.tick) begin
            timer <= timer_inc;
          end
        end
        ST_YELLOW: begin
          if (leave_yellow) begin
            state    <= ST_ALL_RED;
            timer    <= '0;
            yellow_r <= '0;
            red_r    <= '1;
          end else if (bus.tick) begin
            timer <= timer_inc;
          end
        end
        default: begin
          state    <= ST_ALL_RED;
          timer    <= '0;
          green_r  <= '0;
          yellow_r <= '0;
          red_r    <= '1;
        end
      endcase
    end
  end

  assign bus.green    = green_r;
  assign bus.yellow   = yellow_r;
  assign bus.red      = red_r;
  assign bus.cur_appr = cur;
  assign bus.pending  = pend;
  assign bus.grant    = grant_r;

endmodule
